// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M execute-stage multiply/divide unit.
//
// Holds one operation at a time. MUL/MULH/MULHSU/MULHU go through a MUL_STAGES-deep
// multiplier. DIV/DIVU/REM/REMU use a restoring radix-2 divider (one quotient bit per
// cycle) followed by a sign-fix cycle. While an op is in EX and its result is not yet
// ready, stall_req freezes IF/ID/EX.
//
// Optional feature: define MULDIV_DIV_EARLY_OUT_EN to let divide-by-zero and signed
// overflow skip the iteration and finish one cycle after accept. Without it, every
// divide has the same data-independent latency.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start_ex   M-extension op present in EX
//   funct3_ex  op select (000 MUL .. 111 REMU)
//   src_a_ex   rs1 operand (forwarded)
//   src_b_ex   rs2 operand (forwarded)
//   rd_ex      destination tag
//   flush      synchronous abort of the op in flight
//   busy       an operation is in flight
//   stall_req  start_ex & ~done
//   done       one-cycle result-valid pulse
//   result     result, held until the next done
//   rd_out     destination tag of result, held like result
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_ex,
  input  logic [2:0]       funct3_ex,
  input  logic [XLEN-1:0]  src_a_ex,
  input  logic [XLEN-1:0]  src_b_ex,
  input  logic [TAG_W-1:0] rd_ex,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam int unsigned CntW = $clog2(XLEN);

`ifdef MULDIV_DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StDivFix,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;       // funct3[1:0] of the accepted op
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  rd_out_q, rd_out_d;

  // ---------------------------------------------------------------------------
  // Multiplier: operands sign- or zero-extended to 2*XLEN, so the truncated
  // 2*XLEN product is correct for every signedness combination.
  // ---------------------------------------------------------------------------
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod, mul_tap;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a_sgn = (op_q == 2'b01) | (op_q == 2'b10);
    mul_b_sgn = (op_q == 2'b01);
    mul_a_ext = {{XLEN{mul_a_sgn & opa_q[XLEN-1]}}, opa_q};
    mul_b_ext = {{XLEN{mul_b_sgn & opb_q[XLEN-1]}}, opb_q};
    mul_prod  = mul_a_ext * mul_b_ext;
  end

  // The result register is the last multiplier stage; MUL_STAGES-1 stages sit before it.
  if (MUL_STAGES > 1) begin : g_mul_pipe
    logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pipe_q <= '{default: '0};
      end else begin
        pipe_q[0] <= mul_prod;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign mul_tap = pipe_q[MUL_STAGES-2];
  end else begin : g_mul_comb
    assign mul_tap = mul_prod;
  end

  assign mul_res = (op_q == 2'b00) ? mul_tap[XLEN-1:0] : mul_tap[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Divider: magnitudes loaded at accept, one restoring step per DIV cycle.
  // ---------------------------------------------------------------------------
  logic            acc_sgn;
  logic [XLEN-1:0] acc_a_mag, acc_b_mag;

  always_comb begin
    acc_sgn   = ~funct3_ex[0];
    acc_a_mag = (acc_sgn & src_a_ex[XLEN-1]) ? -src_a_ex : src_a_ex;
    acc_b_mag = (acc_sgn & src_b_ex[XLEN-1]) ? -src_b_ex : src_b_ex;
  end

  logic [XLEN:0]   div_shift;
  logic            div_qbit;
  logic [XLEN-1:0] div_rem_next, div_quo_next;

  always_comb begin
    // Partial remainder shifted left, bringing in the next dividend bit (quo_q MSB).
    div_shift    = {rem_q, quo_q[XLEN-1]};
    div_qbit     = (div_shift >= {1'b0, dvs_q});
    div_rem_next = div_qbit ? XLEN'(div_shift - {1'b0, dvs_q}) : div_shift[XLEN-1:0];
    div_quo_next = {quo_q[XLEN-2:0], div_qbit};
  end

  logic            div_sgn, div_is_rem, div_q_neg, div_r_neg;
  logic            div_b_zero, div_ovf, div_special;
  logic [XLEN-1:0] div_q_fix, div_r_fix, div_special_res, div_res;

  always_comb begin
    div_sgn     = ~op_q[0];
    div_is_rem  = op_q[1];
    div_q_neg   = div_sgn & (opa_q[XLEN-1] ^ opb_q[XLEN-1]);
    div_r_neg   = div_sgn & opa_q[XLEN-1];
    div_q_fix   = div_q_neg ? -quo_q : quo_q;
    div_r_fix   = div_r_neg ? -rem_q : rem_q;
    div_b_zero  = (opb_q == '0);
    div_ovf     = div_sgn & (opa_q == {1'b1, {(XLEN-1){1'b0}}}) & (opb_q == '1);
    div_special = div_b_zero | div_ovf;
    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend (most negative value), remainder = 0.
    if (div_b_zero) begin
      div_special_res = div_is_rem ? opa_q : '1;
    end else begin
      div_special_res = div_is_rem ? '0 : opa_q;
    end
    div_res = div_special ? div_special_res : (div_is_rem ? div_r_fix : div_q_fix);
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and register updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    if (flush) begin
      // Abort wins over everything; result and rd_out keep their old values.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ex) begin
            op_d  = funct3_ex[1:0];
            opa_d = src_a_ex;
            opb_d = src_b_ex;
            rd_d  = rd_ex;
            cnt_d = '0;
            if (funct3_ex[2]) begin
              state_d = StDiv;
              rem_d   = '0;
              quo_d   = acc_a_mag;
              dvs_d   = acc_b_mag;
            end else begin
              state_d = StMul;
            end
          end
        end
        StMul: begin
          if (cnt_q == CntW'(MUL_STAGES - 1)) begin
            state_d  = StDone;
            result_d = mul_res;
            rd_out_d = rd_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDiv: begin
          if (EarlyOut && div_special) begin
            state_d  = StDone;
            result_d = div_special_res;
            rd_out_d = rd_q;
          end else begin
            rem_d = div_rem_next;
            quo_d = div_quo_next;
            if (cnt_q == CntW'(XLEN - 1)) begin
              state_d = StDivFix;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StDivFix: begin
          state_d  = StDone;
          result_d = div_res;
          rd_out_d = rd_q;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_comb begin
    busy      = (state_q == StMul) | (state_q == StDiv) | (state_q == StDivFix);
    done      = (state_q == StDone);
    stall_req = start_ex & ~done;
    result    = result_q;
    rd_out    = rd_out_q;
  end

endmodule
